// File: rtl/bypass_ctrl_multi.sv
// Forwarding controller: tracks in-flight destinations over NUM_STAGES result
// stages, resolves each source operand to a bypass stage or the register file.
module bypass_ctrl_multi #(
  parameter int unsigned NUM_STAGES   = 3,
  parameter int unsigned NUM_OPERANDS = 3,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned LAT_W        = $clog2(NUM_STAGES + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               hold,
  input  logic                               flush,
  input  logic                               issue_valid,
  input  logic                               issue_dest_valid,
  input  logic [REG_ADDR_W-1:0]              issue_dest,
  input  logic [LAT_W-1:0]                   issue_lat,
  input  logic [NUM_OPERANDS-1:0]            src_valid,
  input  logic [NUM_OPERANDS*REG_ADDR_W-1:0] src_addr,
  output logic                               stall,
  output logic [NUM_OPERANDS*NUM_STAGES-1:0] sel,
  output logic                               sel_valid
);

  localparam int unsigned SEL_W = NUM_OPERANDS * NUM_STAGES;

  logic [NUM_STAGES-1:0] v;
  logic [REG_ADDR_W-1:0] dest [NUM_STAGES];
  logic [LAT_W-1:0]      rem  [NUM_STAGES];

  logic [SEL_W-1:0] sel_nxt;
  logic             hit_pending;
  logic             accept;
  logic [LAT_W-1:0] lat_eff;

  // Out-of-range latencies saturate to the deepest stage.
  always_comb begin
    lat_eff = issue_lat;
    if (issue_lat == '0 || 32'(issue_lat) > NUM_STAGES) begin
      lat_eff = LAT_W'(NUM_STAGES);
    end
  end

  // Youngest-match lookup per operand; only the youngest match is considered.
  always_comb begin : match
    logic found;
    sel_nxt     = '0;
    hit_pending = 1'b0;
    found       = 1'b0;
    for (int i = 0; i < int'(NUM_OPERANDS); i++) begin
      found = 1'b0;
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        if (!found && src_valid[i] && v[k] &&
            dest[k] == src_addr[i*REG_ADDR_W +: REG_ADDR_W]) begin
          found = 1'b1;
          if (rem[k] == '0) begin
            sel_nxt[i*NUM_STAGES + k] = 1'b1;
          end else begin
            hit_pending = 1'b1;
          end
        end
      end
    end
  end

  assign stall  = issue_valid && hit_pending && !flush;
  assign accept = issue_valid && !stall && !hold && !flush;

  // Table shift, new entry insert and registered select outputs.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v         <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
    end else if (!hold) begin
      for (int k = 1; k < int'(NUM_STAGES); k++) begin
        v[k]    <= v[k-1];
        dest[k] <= dest[k-1];
        rem[k]  <= (rem[k-1] == '0) ? '0 : rem[k-1] - LAT_W'(1);
      end
      v[0]      <= accept && issue_dest_valid;
      dest[0]   <= issue_dest;
      rem[0]    <= lat_eff - LAT_W'(1);
      sel       <= accept ? sel_nxt : '0;
      sel_valid <= accept;
    end
  end

endmodule

// File: tb/tb_bypass_ctrl_multi.sv
// Self-checking bench for bypass_ctrl_multi: directed scenarios then random
// traffic against an age-based in-flight instruction model.
module tb_bypass_ctrl_multi;

  localparam int NS = 3;
  localparam int NO = 3;
  localparam int W  = 5;
  localparam int LW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              hold = 1'b0, flush = 1'b0;
  logic              issue_valid = 1'b0, issue_dest_valid = 1'b0;
  logic [W-1:0]      issue_dest = '0;
  logic [LW-1:0]     issue_lat = '0;
  logic [NO-1:0]     src_valid = '0;
  logic [NO*W-1:0]   src_addr = '0;
  logic              stall;
  logic [NO*NS-1:0]  sel;
  logic              sel_valid;

  bypass_ctrl_multi #(
    .NUM_STAGES(NS), .NUM_OPERANDS(NO), .REG_ADDR_W(W), .LAT_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .issue_valid(issue_valid), .issue_dest_valid(issue_dest_valid),
    .issue_dest(issue_dest), .issue_lat(issue_lat),
    .src_valid(src_valid), .src_addr(src_addr),
    .stall(stall), .sel(sel), .sel_valid(sel_valid)
  );

  // Model: every accepted writer with its age in unfrozen cycles since accept.
  typedef struct {int dest; int lat; int age;} inflight_t;
  inflight_t q[$];
  logic [NO*NS-1:0] exp_sel = '0;
  logic             exp_sv = 1'b0;
  bit               known = 1'b0;
  logic             obs_stall;
  int               tests = 0;
  int               fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cycle(input logic r, input logic h, input logic f, input logic iv,
                          input logic idv, input int id, input int il,
                          input logic [NO-1:0] sv, input int s0, input int s1, input int s2);
    logic [NO*NS-1:0] nsel;
    logic st, acc;
    int srcs[NO];
    int best, le;
    @(negedge clk);
    reset = r; hold = h; flush = f; issue_valid = iv; issue_dest_valid = idv;
    issue_dest = W'(id); issue_lat = LW'(il); src_valid = sv;
    src_addr = {W'(s2), W'(s1), W'(s0)};
    #1;
    srcs = '{s0, s1, s2};
    nsel = '0;
    st = 1'b0;
    for (int i = 0; i < NO; i++) begin
      if (sv[i]) begin
        best = -1;
        for (int j = 0; j < q.size(); j++)
          if (q[j].dest == srcs[i] && (best < 0 || q[j].age < q[best].age)) best = j;
        if (best >= 0) begin
          if (q[best].age >= q[best].lat) nsel[i*NS + q[best].age - 1] = 1'b1;
          else st = 1'b1;
        end
      end
    end
    st  = st && iv && !f;
    acc = iv && !st && !h && !f;
    le  = (il == 0 || il > NS) ? NS : il;
    obs_stall = stall;
    if (known) begin
      chk("stall", 32'(stall), 32'(st));
      chk("sel", 32'(sel), 32'(exp_sel));
      chk("sel_valid", 32'(sel_valid), 32'(exp_sv));
      for (int i = 0; i < NO; i++) begin
        tests++;
        assert ($onehot0(sel[i*NS +: NS])) else begin
          fails++;
          $error("FAIL onehot0 slice %0d observed=%0b expected=onehot0", i, sel[i*NS +: NS]);
        end
      end
    end
    @(posedge clk);
    if (r || f) begin
      q.delete();
      exp_sel = '0;
      exp_sv  = 1'b0;
      if (r) known = 1'b1;
    end else if (!h) begin
      for (int j = 0; j < q.size(); j++) q[j].age++;
      for (int j = q.size() - 1; j >= 0; j--) if (q[j].age > NS) q.delete(j);
      if (acc && idv) q.push_back('{id, le, 1});
      exp_sel = acc ? nsel : '0;
      exp_sv  = acc;
    end
    #1;
  endtask

  task automatic iss(input int d, input int l);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, d, l, 3'b000, 0, 0, 0);
  endtask

  task automatic rd(input logic [NO-1:0] sv, input int s0, input int s1, input int s2);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, sv, s0, s1, s2);
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 3'b000, 0, 0, 0);
  endtask

  initial begin
    // Reset
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 3'b000, 0, 0, 0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 3'b000, 0, 0, 0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_sel_valid", 32'(sel_valid), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);

    // Latency-1 result forwarded from stage 0
    iss(3, 1);
    rd(3'b001, 3, 0, 0);
    chk("t2_stall", 32'(obs_stall), 32'h0);
    chk("t2_sel0", 32'(sel[2:0]), 32'h1);
    chk("t2_sel_valid", 32'(sel_valid), 32'h1);

    // Latency-2 result: one stall cycle, then stage 1
    iss(4, 2);
    rd(3'b010, 0, 4, 0);
    chk("t3_stall", 32'(obs_stall), 32'h1);
    chk("t3_stalled_sv", 32'(sel_valid), 32'h0);
    rd(3'b010, 0, 4, 0);
    chk("t3_retry_stall", 32'(obs_stall), 32'h0);
    chk("t3_sel1", 32'(sel[5:3]), 32'h2);

    // Two writers of r5: youngest wins
    iss(5, 1);
    iss(5, 1);
    rd(3'b100, 0, 0, 5);
    chk("t4_sel2", 32'(sel[8:6]), 32'h1);

    // Retired result comes from the register file
    iss(6, 1);
    repeat (NS) idle();
    rd(3'b001, 6, 0, 0);
    chk("t5_stall", 32'(obs_stall), 32'h0);
    chk("t5_sel", 32'(sel), 32'h0);
    chk("t5_sel_valid", 32'(sel_valid), 32'h1);

    // Hold during a stall, then flush
    iss(7, 3);
    repeat (3) begin
      do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 3'b001, 7, 0, 0);
      chk("t6_hold_stall", 32'(obs_stall), 32'h1);
      chk("t6_hold_sv", 32'(sel_valid), 32'h1);
    end
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 3'b001, 7, 0, 0);
    chk("t6_flush_stall", 32'(obs_stall), 32'h0);
    chk("t6_flush_sv", 32'(sel_valid), 32'h0);
    rd(3'b001, 7, 0, 0);
    chk("t6_post_stall", 32'(obs_stall), 32'h0);
    chk("t6_post_sel", 32'(sel), 32'h0);

    // Random traffic on a small register window to provoke hits
    for (int n = 0; n < 500; n++) begin
      do_cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), 3'($urandom),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
